pkt_lane_scheduler: RTL

//  Front-end controller for the packet inspector datapath. Runs LANES independent serial lanes:
//  - Each lane hunts for the sync word, captures a PKT_BITS packet and extracts port/session header fields.
//  - A round-robin arbiter hands completed headers one at a time to the shared classifier/counter stage

---
 rtl/pkt_lane_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pkt_lane_scheduler.sv
// Per-lane sync hunt and header capture with a round-robin handoff
// of completed headers to the shared classifier over valid/ready.
module pkt_lane_scheduler #(
  parameter int          LANES    = 4,
  parameter logic [31:0] SYNC     = 32'hA5A5A5A5,
  parameter int          PKT_BITS = 256,
  parameter int          PORT_OFS = 64,
  parameter int          SESS_OFS = 136,
  localparam int         LW       = $clog2(LANES),
  localparam int         CW       = $clog2(PKT_BITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANES-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LW-1:0]      out_lane,
  output logic [15:0]        out_port,
  output logic [7:0]         out_session,
  output logic [LANES-1:0]   lane_busy,
  output logic [8*LANES-1:0] overrun_cnt,
  output logic [31:0]        total_cnt
);

  typedef enum logic [1:0] {
    HUNT,
    CAPTURE,
    HOLD
  } st_e;

  st_e           r_st   [LANES];
  logic [31:0]   r_sh   [LANES];
  logic [CW-1:0] r_cnt  [LANES];
  logic [15:0]   r_port [LANES];
  logic [7:0]    r_sess [LANES];
  logic [7:0]    r_ovr  [LANES];

  logic          r_valid;
  logic [LW-1:0] r_lane;
  logic [15:0]   r_oport;
  logic [7:0]    r_osess;
  logic [LW-1:0] r_last;
  logic [31:0]   r_total;

  logic [31:0]      w_shn [LANES];
  logic [LANES-1:0] w_match;
  logic [LANES-1:0] w_hold;
  logic [LANES-1:0] w_gnt;
  logic             w_load;
  logic             w_found;
  logic [LW-1:0]    w_sel;
  logic [LW-1:0]    w_idx;

  always_comb begin
    lane_busy   = '0;
    overrun_cnt = '0;
    w_match     = '0;
    w_hold      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_shn[i]   = {r_sh[i][30:0], in_data[i]};
      w_match[i] = (w_shn[i] == SYNC);
      w_hold[i]  = (r_st[i] == HOLD);
      lane_busy[i] = (r_st[i] != HUNT);
      overrun_cnt[8*i +: 8] = r_ovr[i];
    end
  end

  // First HOLD lane after the last grant, wrapping around.
  always_comb begin
    w_load  = !r_valid || out_ready;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= LANES; k++) begin
      w_idx = LW'((int'(r_last) + k) % LANES);
      if (!w_found && w_hold[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_gnt = '0;
    if (w_load && w_found)
      w_gnt[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_st[i]   <= HUNT;
        r_sh[i]   <= '0;
        r_cnt[i]  <= '0;
        r_port[i] <= '0;
        r_sess[i] <= '0;
        r_ovr[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        unique case (r_st[i])
          HUNT: begin
            if (w_match[i]) begin
              r_st[i]  <= CAPTURE;
              r_cnt[i] <= '0;
              r_sh[i]  <= '0;
            end else begin
              r_sh[i] <= w_shn[i];
            end
          end
          CAPTURE: begin
            r_sh[i]  <= w_shn[i];
            r_cnt[i] <= r_cnt[i] + 1'b1;
            if (int'(r_cnt[i]) >= PORT_OFS &&
                int'(r_cnt[i]) < PORT_OFS + 16)
              r_port[i] <= {r_port[i][14:0], in_data[i]};
            if (int'(r_cnt[i]) >= SESS_OFS &&
                int'(r_cnt[i]) < SESS_OFS + 8)
              r_sess[i] <= {r_sess[i][6:0], in_data[i]};
            if (r_cnt[i] == CW'(PKT_BITS - 1)) begin
              r_st[i] <= HOLD;
              r_sh[i] <= '0;
            end
          end
          HOLD: begin
            // A grant wins over a sync that lands on the same edge.
            if (w_gnt[i]) begin
              r_st[i] <= HUNT;
              r_sh[i] <= '0;
            end else if (w_match[i]) begin
              r_sh[i] <= '0;
              if (r_ovr[i] != 8'hFF)
                r_ovr[i] <= r_ovr[i] + 8'd1;
            end else begin
              r_sh[i] <= w_shn[i];
            end
          end
          default: begin
            r_st[i] <= HUNT;
            r_sh[i] <= '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_lane  <= '0;
      r_oport <= '0;
      r_osess <= '0;
      r_last  <= LW'(LANES - 1);
      r_total <= '0;
    end else begin
      if (w_load && w_found) begin
        r_valid <= 1'b1;
        r_lane  <= w_sel;
        r_oport <= r_port[w_sel];
        r_osess <= r_sess[w_sel];
        r_last  <= w_sel;
      end else if (w_load) begin
        r_valid <= 1'b0;
      end
      if (r_valid && out_ready)
        r_total <= r_total + 32'd1;
    end
  end

  assign out_valid   = r_valid;
  assign out_lane    = r_lane;
  assign out_port    = r_oport;
  assign out_session = r_osess;
  assign total_cnt   = r_total;

endmodule
